// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembler; word_o already includes the byte accepted this cycle.
module word_packer
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH = 8 * BYTES_PER_WORD,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  accept,
   input  logic [IDX_W-1:0]      idx,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word_o
);

   logic [DATA_WIDTH-1:0] word_q;
   logic [DATA_WIDTH-1:0] word_d;

   // Merge the incoming byte into its lane of the partial word.
   always_comb begin
      word_d = word_q;
      if (clr) begin
         word_d = {DATA_WIDTH{1'b0}};
      end else if (accept) begin
         word_d[8*idx +: 8] = byte_in;
      end else begin
         word_d = word_q;
      end
   end

   // Partial word register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= {DATA_WIDTH{1'b0}};
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o = word_d;

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory one word at a time while stalling the CPU.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8 * BYTES_PER_WORD,
   parameter int TIMEOUT       = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic [ADDRESS_WIDTH:0]   load_len,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_stall,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [ADDRESS_WIDTH:0] MAX_LEN  = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH:0]   len_q, len_d;
   logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic                     byte_ready_q, byte_ready_d;
   logic                     mem_we_q, mem_we_d;
   logic [ADDRESS_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                     busy_q, busy_d;
   logic                     cpu_stall_q, cpu_stall_d;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     accept_s, clr_s, len_ok_s;
   logic [DATA_WIDTH-1:0]    word_s;

   assign accept_s = byte_valid & byte_ready_q;
   assign len_ok_s = (load_len != {(ADDRESS_WIDTH+1){1'b0}}) && (load_len <= MAX_LEN);

   word_packer #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_packer (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_s),
      .accept  (accept_s),
      .idx     (idx_q),
      .byte_in (byte_data),
      .word_o  (word_s)
   );

   // Next-state and output-register decode.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
      err_d       = 1'b0;
      clr_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start && len_ok_s) begin
               state_d = ST_LOAD;
               len_d   = load_len;
               ptr_d   = {ADDRESS_WIDTH{1'b0}};
               idx_d   = {IDX_W{1'b0}};
               tmo_d   = {TW{1'b0}};
               clr_s   = 1'b1;
            end else if (load_start) begin
               err_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (accept_s) begin
               tmo_d = {TW{1'b0}};
               if (idx_q == LAST_IDX) begin
                  state_d     = ST_WRITE;
                  mem_waddr_d = ptr_q;
                  mem_wdata_d = word_s;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (tmo_q == TMO_LAST) begin
               // Source stalled too long: abandon the load and its partial word.
               state_d = ST_IDLE;
               err_d   = 1'b1;
               clr_s   = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_WRITE: begin
            if (({1'b0, ptr_q} + (ADDRESS_WIDTH+1)'(1)) == len_q) begin
               state_d = ST_DONE;
            end else begin
               ptr_d   = ptr_q + ADDRESS_WIDTH'(1);
               idx_d   = {IDX_W{1'b0}};
               state_d = ST_LOAD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      byte_ready_d = (state_d == ST_LOAD);
      mem_we_d     = (state_d == ST_WRITE);
      busy_d       = (state_d != ST_IDLE);
      cpu_stall_d  = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         len_q        <= {(ADDRESS_WIDTH+1){1'b0}};
         ptr_q        <= {ADDRESS_WIDTH{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         tmo_q        <= {TW{1'b0}};
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_waddr_q  <= {ADDRESS_WIDTH{1'b0}};
         mem_wdata_q  <= {DATA_WIDTH{1'b0}};
         busy_q       <= 1'b0;
         cpu_stall_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         tmo_q        <= tmo_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_waddr_q  <= mem_waddr_d;
         mem_wdata_q  <= mem_wdata_d;
         busy_q       <= busy_d;
         cpu_stall_q  <= cpu_stall_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_waddr  = mem_waddr_q;
   assign mem_wdata  = mem_wdata_q;
   assign busy       = busy_q;
   assign cpu_stall  = cpu_stall_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: word-address width of the instruction memory write port.
REQ-002 Parameter DATA_WIDTH, default 32: instruction word width; SHALL be a multiple of 8; BYTES = DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 1024: maximum idle cycles allowed between accepted bytes during a load.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 load_start  input  1  one-cycle request to begin a program load.
REQ-008 load_len  input  ADDRESS_WIDTH+1  number of words to load; sampled with load_start.
REQ-009 byte_valid  input  1  byte source has data.
REQ-010 byte_data  input  8  program byte.
REQ-011 byte_ready  output  1  loader accepts a byte this cycle.
REQ-012 mem_we  output  1  instruction memory write strobe.
REQ-013 mem_waddr  output  ADDRESS_WIDTH  word address being written.
REQ-014 mem_wdata  output  DATA_WIDTH  word being written.
REQ-015 cpu_stall  output  1  holds the CPU fetch/PC while memory is being rewritten.
REQ-016 busy  output  1  load in progress.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 err  output  1  one-cycle pulse on rejected request or timeout.

Function
REQ-019 States: IDLE, LOAD, WRITE, DONE.
REQ-020 IDLE: byte_ready=0, cpu_stall=0, busy=0; on load_start with 1 <= load_len <= 2**ADDRESS_WIDTH go to LOAD, capture load_len, clear word pointer, byte index and timeout counter.
REQ-021 IDLE with load_start and load_len==0 or load_len > 2**ADDRESS_WIDTH: stay in IDLE, pulse err next cycle.
REQ-022 LOAD: byte_ready=1; a byte is accepted when byte_valid and byte_ready are both high in the same cycle.
REQ-023 Byte packing is little-endian: byte k of a word (k = 0..BYTES-1) lands in bits [8k+7:8k].
REQ-024 Acceptance of byte BYTES-1 moves the FSM to WRITE on the next edge; byte_ready=0 in WRITE.
REQ-025 WRITE lasts exactly one cycle: mem_we=1, mem_waddr=word pointer, mem_wdata=assembled word; no other cycle asserts mem_we.
REQ-026 Leaving WRITE: if word pointer+1 == captured length go to DONE, else increment the pointer, clear byte index, return to LOAD.
REQ-027 DONE lasts one cycle: done=1, then IDLE.
REQ-028 cpu_stall=1 and busy=1 in LOAD, WRITE and DONE.
REQ-029 Timeout counter increments each LOAD cycle without an accepted byte and clears on every accepted byte; reaching TIMEOUT aborts to IDLE with an err pulse, no write, and partial word discarded.
REQ-030 load_start outside IDLE SHALL be ignored.
REQ-031 Word pointer SHALL never wrap: the maximum length writes addresses 0 .. 2**ADDRESS_WIDTH-1 exactly once.

Reset
REQ-032 On rst: state=IDLE; byte_ready, mem_we, cpu_stall, busy, done, err = 0; mem_waddr, mem_wdata, pointer, byte index, timeout counter = 0.
REQ-033 Reset mid-load abandons the load immediately; no further write occurs after rst deasserts.

Structure
REQ-034 Shared package imem_pkg SHALL hold the state enum type and the BYTES_PER_WORD constant.
REQ-035 Byte packing SHALL be a sub-module word_packer (byte in, index, accept, word out); FSM and counters stay in imem_loader.

Verification
REQ-036 load_len=2, bytes 13 00 00 00 93 00 10 00 with valid always high -> writes addr0=0x00000013, addr1=0x00100093; done pulses once; cpu_stall high from the cycle after load_start through DONE.
REQ-037 load_len=1, byte_valid toggling 1/0 each cycle -> single write 0xDDCCBBAA for bytes AA BB CC DD; byte_ready low during WRITE.
REQ-038 load_len=0, then load_len=257 (ADDRESS_WIDTH=8) -> err pulse each time, FSM stays IDLE, no mem_we.
REQ-039 TIMEOUT=16, two bytes then no valid for 16 cycles -> err pulse, return to IDLE, cpu_stall=0, no write.
REQ-040 rst asserted after 3 words of a 5-word load -> all outputs zero asynchronously; subsequent 1-word load writes addr0.
REQ-041 load_len=256 with random valid gaps shorter than TIMEOUT -> 256 writes, addresses 0..255 each exactly once, and a second load_start pulsed during the load is ignored.
